// File: rtl/bitmap_window_loader_pkg.sv
// Shared definitions for the bitmap window loader: default geometry, sequencer
// state encoding, and the accelerator's note/length code sets.
package bitmap_window_loader_pkg;

  localparam int unsigned WinRows    = 64;
  localparam int unsigned WinRowW    = 24;
  localparam int unsigned WinW       = WinRows * WinRowW;
  localparam int unsigned WinAddrW   = 16;
  localparam int unsigned WinStride  = 1;
  localparam int unsigned WinTimeout = 1023;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDrain,
    StKick,
    StWait,
    StCapture,
    StHold
  } state_e;

  // Codes the match accelerator can report.
  localparam logic [15:0] NoteCodes [7] = '{16'h000A, 16'h000B, 16'h000C, 16'h000D,
                                            16'h000E, 16'h000F, 16'h0001};
  localparam logic [15:0] LenCodes  [2] = '{16'h0010, 16'h0001};

endpackage

// File: rtl/bitmap_window_loader_row_writer.sv
// window_row_writer: lagged write pointer plus the ROWS x ROW_W row bank.
// A read issued for row k in one cycle returns data the next cycle, which is
// written into bmr_o[RowW*k +: RowW] (row 0 at the LSBs).
// Ports:
//   clk_i, rst_ni  clock, async active-low reset
//   rd_i           read issued this cycle
//   rd_idx_i       row index of the read issued this cycle
//   rdata_i        memory data for the read issued last cycle
//   bmr_o          assembled flat window
module window_row_writer
  import bitmap_window_loader_pkg::*;
#(
  parameter int unsigned Rows = WinRows,
  parameter int unsigned RowW = WinRowW,
  localparam int unsigned IdxW = $clog2(Rows)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rd_i,
  input  logic [IdxW-1:0]      rd_idx_i,
  input  logic [RowW-1:0]      rdata_i,
  output logic [Rows*RowW-1:0] bmr_o
);

  logic            wr_en_q;
  logic [IdxW-1:0] wr_idx_q;
  logic [RowW-1:0] rows_q [Rows];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_en_q  <= 1'b0;
      wr_idx_q <= '0;
    end else begin
      wr_en_q  <= rd_i;
      wr_idx_q <= rd_idx_i;
    end
  end

  for (genvar r = 0; r < Rows; r++) begin : g_row
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        rows_q[r] <= '0;
      end else if (wr_en_q && (wr_idx_q == IdxW'(r))) begin
        rows_q[r] <= rdata_i;
      end
    end
    assign bmr_o[r*RowW +: RowW] = rows_q[r];
  end

endmodule

// File: rtl/bitmap_window_loader.sv
// bitmap_window_loader: fetches a ROWS-row bitmap window from synchronous
// memory, starts the match accelerator, waits for finish (with timeout) and
// hands the captured note/length codes to the controller via valid/ack.
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   go_i, base_addr_i, busy_o     request, window base address, busy flag
//   mem_rd_o, mem_addr_o, mem_rdata_i  image memory read port (1-cycle latency)
//   bmr_o, start_o, finish_i      accelerator window, start pulse, done
//   note_reg_i, length_reg_i      accelerator result codes
//   result_valid_o, result_ack_i  result handshake
//   note_out_o, length_out_o, err_o  captured result, timeout flag
module bitmap_window_loader
  import bitmap_window_loader_pkg::*;
#(
  parameter int unsigned Rows    = WinRows,
  parameter int unsigned RowW    = WinRowW,
  parameter int unsigned AddrW   = WinAddrW,
  parameter int unsigned Stride  = WinStride,
  parameter int unsigned Timeout = WinTimeout
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 go_i,
  input  logic [AddrW-1:0]     base_addr_i,
  output logic                 mem_rd_o,
  output logic [AddrW-1:0]     mem_addr_o,
  input  logic [RowW-1:0]      mem_rdata_i,
  output logic [Rows*RowW-1:0] bmr_o,
  output logic                 start_o,
  input  logic                 finish_i,
  input  logic [15:0]          note_reg_i,
  input  logic [15:0]          length_reg_i,
  output logic                 busy_o,
  output logic                 result_valid_o,
  input  logic                 result_ack_i,
  output logic [15:0]          note_out_o,
  output logic [15:0]          length_out_o,
  output logic                 err_o
);

  localparam int unsigned IdxW = $clog2(Rows);
  localparam int unsigned TcntW = $clog2(Timeout + 1);

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [AddrW-1:0]  base_q, base_d;
  logic [TcntW-1:0]  tcnt_q, tcnt_d;
  logic [15:0]       note_q, note_d;
  logic [15:0]       len_q, len_d;
  logic              err_q, err_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      idx_q   <= '0;
      base_q  <= '0;
      tcnt_q  <= '0;
      note_q  <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
      tcnt_q  <= tcnt_d;
      note_q  <= note_d;
      len_q   <= len_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    base_d         = base_q;
    tcnt_d         = tcnt_q;
    note_d         = note_q;
    len_d          = len_q;
    err_d          = err_q;
    mem_rd_o       = 1'b0;
    start_o        = 1'b0;
    result_valid_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (go_i) begin
          base_d  = base_addr_i;
          idx_d   = '0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        mem_rd_o = 1'b1;
        if (idx_q == IdxW'(Rows - 1)) begin
          state_d = StDrain;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      // Last row's data lands this cycle; the row writer stores it.
      StDrain: state_d = StKick;
      StKick: begin
        start_o = 1'b1;
        tcnt_d  = '0;
        state_d = StWait;
      end
      StWait: begin
        if (finish_i) begin
          state_d = StCapture;
        end else if (tcnt_q == TcntW'(Timeout - 1)) begin
          err_d   = 1'b1;
          note_d  = '0;
          len_d   = '0;
          state_d = StHold;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      // lengthReg settles one cycle after finish, so sample here.
      StCapture: begin
        note_d  = note_reg_i;
        len_d   = length_reg_i;
        err_d   = 1'b0;
        state_d = StHold;
      end
      StHold: begin
        result_valid_o = 1'b1;
        if (result_ack_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy_o       = (state_q != StIdle);
  assign mem_addr_o   = mem_rd_o ? (base_q + AddrW'(idx_q) * AddrW'(Stride)) : '0;
  assign note_out_o   = note_q;
  assign length_out_o = len_q;
  assign err_o        = err_q;

  window_row_writer #(
    .Rows(Rows),
    .RowW(RowW)
  ) u_row_writer (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .rd_i    (mem_rd_o),
    .rd_idx_i(idx_q),
    .rdata_i (mem_rdata_i),
    .bmr_o   (bmr_o)
  );

endmodule

// File: doc/bitmap_window_loader.md
Name: bitmap_window_loader

Overview:
- Upstream feeder for the note/length match accelerator.
- Fetches a 64-row x 24-bit bitmap window from synchronous image memory and assembles the 1536-bit flat window.
- Pulses start, waits for finish, captures the accelerator's note and length codes, and presents them to the control processor with a valid/ack handshake.
- Includes a timeout so a hung match never locks the pipeline.

Parameters:
ROWS, 64, rows per window
ROW_W, 24, bits per row (window width = ROWS*ROW_W = 1536)
ADDR_W, 16, image memory address width
STRIDE, 1, address increment between consecutive rows
TIMEOUT, 1023, max cycles waiting for finish before flagging error

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
go  in  1  one-cycle request to process a window; ignored while busy=1
base_addr  in  ADDR_W  address of row 0, sampled when go is accepted
mem_rd  out  1  memory read strobe
mem_addr  out  ADDR_W  memory read address
mem_rdata  in  ROW_W  read data, valid exactly one cycle after mem_rd
bmr  out  ROWS*ROW_W  assembled window to accelerator
start  out  1  one-cycle accelerator start pulse
finish  in  1  accelerator done
noteReg  in  16  accelerator note code
lengthReg  in  16  accelerator length code
busy  out  1  high from go acceptance until return to IDLE
result_valid  out  1  note_out/length_out/err valid
result_ack  in  1  consumer accepts result
note_out  out  16  captured note code
length_out  out  16  captured length code
err  out  1  timeout occurred; codes forced to 0

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0, bmr all zeros, counters 0.
- States: IDLE, FETCH, DRAIN, KICK, WAIT, CAPTURE, HOLD.
- IDLE:
  - go=1 latches base_addr, clears row counter, sets busy, moves to FETCH.
  - bmr keeps its previous contents until overwritten row by row.
- FETCH:
  - mem_rd=1 each cycle, mem_addr = base + idx*STRIDE mod 2^ADDR_W.
  - idx runs 0..ROWS-1.
  - When idx = ROWS-1 issues, go to DRAIN.
- Write-back:
  - Data returned in the cycle after a read of row k is written to bmr[ROW_W*k+ROW_W-1 : ROW_W*k]; row 0 sits at the LSBs.
  - The write pointer lags the issue pointer by one cycle.
- DRAIN: mem_rd=0; writes the last row; next KICK.
- KICK: start=1 for exactly one cycle; timeout counter cleared; next WAIT.
- WAIT:
  - Counts cycles.
  - finish=1 moves to CAPTURE.
  - If the count reaches TIMEOUT with no finish, set err=1, note_out=length_out=0, go to HOLD.
- CAPTURE:
  - Exists because the accelerator updates lengthReg one cycle after finish.
  - Samples noteReg/lengthReg into note_out/length_out, err=0, next HOLD.
- HOLD:
  - result_valid=1; outputs stable until result_ack=1.
  - On ack: result_valid=0, busy=0, go to IDLE.
  - go in the same cycle as ack is ignored.
- Latency: go at edge 0 gives mem_rd high for 64 cycles, start pulse at cycle ROWS+2, result_valid at (cycle finish is first seen) + 2.
- finish asserted in KICK (spurious) is ignored; only WAIT observes it.
- result_ack outside HOLD is ignored.
- Async reset mid-fetch or mid-wait aborts immediately: no start pulse is emitted afterwards, and result_valid drops.
- Address wrap: base near 2^ADDR_W wraps silently to 0.

Decomposition:
- Shared package:
  - state encoding enum.
  - constants ROWS/ROW_W/window width.
  - note code set (0x000A..0x000F, 0x0001) and length codes (0x0010, 0x0001), so benches and the sequencer share them.
- One natural sub-module: window_row_writer. It is the lagged write-pointer plus row-slice register bank (ROWS x ROW_W with per-row enable).

Test Plan:
- Reset then base_addr=0x0100, go, memory row k = 24'h0000k: mem_addr steps 0x0100..0x013F over 64 consecutive cycles; bmr[47:24]=24'h000001, bmr[1535:1512]=24'h00003F; single start pulse at cycle 66.
- Accelerator model drives finish 20 cycles after start, noteReg=0x000C, lengthReg=0x0010 one cycle later: note_out=0x000C, length_out=0x0010, err=0, result_valid held 5 cycles until ack, then busy=0.
- finish never asserted, TIMEOUT=1023: result_valid rises 1024 cycles after start with err=1, note_out=length_out=0.
- go pulsed again during FETCH and during HOLD: no address restart, no second start; only one result.
- base_addr=0xFFF0, STRIDE=1: mem_addr sequence 0xFFF0..0xFFFF, 0x0000..0x002F.
- rst low at row 30 of fetch: all outputs 0 immediately; start never pulses; fresh go afterwards completes normally from row 0.
